wb_arbiter_rr2: RTL and testbench

//  Two-master round-robin arbiter for a Wishbone B4 pipelined bus (cyc/stb/stall/ack).

---
 rtl/wb_arbiter_rr2.sv | 147 ++++++++++++++
 tb/tb_wb_arbiter_rr2.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_rr2.sv
// rtl/wb_arbiter_rr2.sv - two-master round-robin arbiter for a pipelined Wishbone slave port
//
// Shares one Wishbone B4 pipelined slave port between masters m0 and m1.
// The grant is held for a whole bus cycle (cyc high).
// Accepted-but-unacked requests are counted and capped at MAX_OUTST.
// The slave-side data path is purely combinational from the master inputs and the grant state.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   mN_cyc/stb/we/adr/dat_w (N=0,1)    master request inputs
//   mN_stall/ack/dat_r                 master response outputs
//   s_cyc/stb/we/adr/dat_w             slave request outputs
//   s_stall/ack/dat_r                  slave response inputs

module wb_arbiter_rr2 #(
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [ADR_WIDTH-1:0] m0_adr,
  input  logic [DAT_WIDTH-1:0] m0_dat_w,
  output logic                 m0_stall,
  output logic                 m0_ack,
  output logic [DAT_WIDTH-1:0] m0_dat_r,
  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [ADR_WIDTH-1:0] m1_adr,
  input  logic [DAT_WIDTH-1:0] m1_dat_w,
  output logic                 m1_stall,
  output logic                 m1_ack,
  output logic [DAT_WIDTH-1:0] m1_dat_r,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [ADR_WIDTH-1:0] s_adr,
  output logic [DAT_WIDTH-1:0] s_dat_w,
  input  logic                 s_stall,
  input  logic                 s_ack,
  input  logic [DAT_WIDTH-1:0] s_dat_r
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] OUTST_MAX = CW'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] outst, outst_nxt;

  logic                 cap;
  logic                 own_cyc, own_stb, own_we, own_stall;
  logic [ADR_WIDTH-1:0] own_adr;
  logic [DAT_WIDTH-1:0] own_dat;
  logic                 acc, ack_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      outst <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      outst <= outst_nxt;
    end
  end

  assign cap     = (outst == OUTST_MAX);
  assign own_cyc = (state == GNT1) ? m1_cyc   : m0_cyc;
  assign own_stb = (state == GNT1) ? m1_stb   : m0_stb;
  assign own_we  = (state == GNT1) ? m1_we    : m0_we;
  assign own_adr = (state == GNT1) ? m1_adr   : m0_adr;
  assign own_dat = (state == GNT1) ? m1_dat_w : m0_dat_w;

  // Read data is fanned out to both masters; only the owner sees ack.
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    outst_nxt = outst;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_w   = '0;
    own_stall = 1'b1;
    acc       = 1'b0;
    ack_ok    = 1'b0;

    if (state != IDLE) begin
      s_cyc     = own_cyc;
      // No new request is offered while the outstanding counter is full.
      s_stb     = own_cyc & own_stb & ~cap;
      s_we      = own_we;
      s_adr     = own_adr;
      s_dat_w   = own_dat;
      own_stall = s_stall | cap;
      acc       = s_stb & ~s_stall;
      // An ack with nothing outstanding is a leftover from an aborted cycle.
      ack_ok    = s_ack & (outst != '0);
    end

    m0_stall = (state == GNT0) ? own_stall : 1'b1;
    m1_stall = (state == GNT1) ? own_stall : 1'b1;
    m0_ack   = (state == GNT0) & ack_ok;
    m1_ack   = (state == GNT1) & ack_ok;

    case (state)
      IDLE: begin
        outst_nxt = '0;
        // last only moves on a real tie, so a lone requester does not steal the next tie.
        if (m0_cyc && m1_cyc) begin
          state_nxt = last ? GNT0 : GNT1;
          last_nxt  = last ? 1'b0 : 1'b1;
        end else if (m0_cyc) begin
          state_nxt = GNT0;
        end else if (m1_cyc) begin
          state_nxt = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!own_cyc) begin
          // Dropping cyc aborts the cycle; pending acks are discarded.
          state_nxt = IDLE;
          outst_nxt = '0;
        end else begin
          case ({acc, ack_ok})
            2'b10:   outst_nxt = outst + CW'(1);
            2'b01:   outst_nxt = outst - CW'(1);
            default: outst_nxt = outst;
          endcase
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_rr2.sv
// tb/tb_wb_arbiter_rr2.sv - directed self-checking bench for wb_arbiter_rr2

module tb_wb_arbiter_rr2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we;
  logic [15:0] m0_adr, m0_dat_w, m0_dat_r;
  logic        m0_stall, m0_ack;
  logic        m1_cyc, m1_stb, m1_we;
  logic [15:0] m1_adr, m1_dat_w, m1_dat_r;
  logic        m1_stall, m1_ack;
  logic        s_cyc, s_stb, s_we, s_stall, s_ack;
  logic [15:0] s_adr, s_dat_w, s_dat_r;

  int checks   = 0;
  int failures = 0;

  // slave model controls and statistics
  int  ack_delay = 1;
  bit  stall_en  = 1'b0;
  int  cyc_cnt   = 0;
  int  acc_cnt   = 0;
  int  sack_cnt  = 0;
  int  due_q[$];
  logic [15:0] dat_q[$];
  logic [15:0] mem [0:255];
  logic [15:0] rdq[$];

  always #5 clk = ~clk;

  wb_arbiter_rr2 dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_w(m0_dat_w),
    .m0_stall(m0_stall), .m0_ack(m0_ack), .m0_dat_r(m0_dat_r),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_w(m1_dat_w),
    .m1_stall(m1_stall), .m1_ack(m1_ack), .m1_dat_r(m1_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_stall(s_stall), .s_ack(s_ack), .s_dat_r(s_dat_r)
  );

  // Pipelined slave: stalls every third cycle when enabled, acks ack_delay cycles after acceptance.
  assign s_stall = stall_en && (cyc_cnt % 3 == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      due_q.delete();
      dat_q.delete();
      s_ack   <= 1'b0;
      s_dat_r <= 16'h0;
    end else begin
      cyc_cnt <= cyc_cnt + 1;
      s_ack   <= 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc_cnt) begin
        s_ack    <= 1'b1;
        s_dat_r  <= dat_q[0];
        sack_cnt <= sack_cnt + 1;
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      if (s_cyc && s_stb && !s_stall) begin
        if (s_we) mem[s_adr[7:0]] <= s_dat_w;
        due_q.push_back(cyc_cnt + ack_delay);
        dat_q.push_back(s_we ? 16'h0 : mem[s_adr[7:0]]);
        acc_cnt <= acc_cnt + 1;
      end
    end
  end

  task automatic drive(input int id, input bit cyc, input bit stb, input bit we, input int adr);
    if (id == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr[15:0]; m0_dat_w = 16'(adr + 200);
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr[15:0]; m1_dat_w = 16'(adr + 200);
    end
  endtask

  // Issues n pipelined requests at a0.. (write data = 200 + address); optionally waits for all acks.
  // acc_first is the number of accepted requests when the first slave ack is seen.
  task automatic burst(input int id, input int n, input bit we, input int a0, input bit wait_ack,
                       output int acks, output int other, output int acc_first);
    int  issued = 0;
    int  t = 0;
    bit  acc_prev = 1'b0;
    acks = 0; other = 0; acc_first = -1;
    while ((issued < n || (wait_ack && acks < issued)) && t < 400) begin
      @(negedge clk);
      t++;
      if ((id == 0) ? m0_ack : m1_ack) begin
        acks++;
        if (!we) rdq.push_back((id == 0) ? m0_dat_r : m1_dat_r);
      end
      if ((id == 0) ? m1_ack : m0_ack) other++;
      if (acc_prev) issued++;
      if (s_ack && acc_first < 0) acc_first = issued;
      drive(id, 1'b1, issued < n, we, a0 + issued);
      #1;
      acc_prev = (issued < n) && !((id == 0) ? m0_stall : m1_stall);
    end
    checks++;
    if (t >= 400) begin
      failures++;
      $display("FAIL burst_timeout id=%0d issued=%0d acks=%0d required=%0d", id, issued, acks, n);
    end
  endtask

  task automatic release_bus(input int id);
    @(negedge clk);
    drive(id, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (s_cyc !== 1'b0) begin failures++; $display("FAIL reset_s_cyc got=%b exp=0", s_cyc); end
    checks++;
    if ({m0_stall, m1_stall} !== 2'b11) begin failures++; $display("FAIL reset_stalls got=%b exp=11", {m0_stall, m1_stall}); end
    checks++;
    if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL reset_acks got=%b exp=00", {m0_ack, m1_ack}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({s_cyc, m0_stall, m1_stall} !== 3'b011) begin
      failures++; $display("FAIL idle_after_reset got=%b exp=011", {s_cyc, m0_stall, m1_stall});
    end
  endtask

  task automatic test_single();
    int acks, other, af;
    stall_en = 1'b1;
    ack_delay = 1;
    burst(0, 10, 1'b1, 11, 1'b1, acks, other, af);
    checks++;
    if (acks !== 10) begin failures++; $display("FAIL single_write_acks got=%0d exp=10", acks); end
    checks++;
    if (other !== 0) begin failures++; $display("FAIL single_write_m1_ack got=%0d exp=0", other); end
    release_bus(0);
    ack_delay = 3;
    rdq.delete();
    burst(0, 10, 1'b0, 11, 1'b1, acks, other, af);
    checks++;
    if (acks !== 10 || other !== 0) begin
      failures++; $display("FAIL single_read_acks got=%0d/%0d exp=10/0", acks, other);
    end
    checks++;
    if (rdq.size() !== 10) begin
      failures++; $display("FAIL readback_count got=%0d exp=10", rdq.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (rdq[i] !== 16'(211 + i)) begin
          failures++; $display("FAIL readback_data idx=%0d got=%0d exp=%0d", i, rdq[i], 211 + i);
        end
      end
    end
    release_bus(0);
    stall_en = 1'b0;
  endtask

  task automatic test_contention();
    do_reset();
    @(negedge clk);
    drive(0, 1, 0, 0, 'hA0);
    drive(1, 1, 0, 0, 'hB1);
    @(negedge clk); #1;
    checks++;
    if ({s_cyc, s_adr, m1_stall} !== {1'b1, 16'h00A0, 1'b1}) begin
      failures++; $display("FAIL c1_gnt0 got=%b/%h/%b exp=1/00a0/1", s_cyc, s_adr, m1_stall);
    end
    drive(0, 0, 0, 0, 'hA0);
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin failures++; $display("FAIL c1_release_comb got=%b exp=0", s_cyc); end
    @(negedge clk); #1;
    checks++;
    if ({s_cyc, m1_stall} !== 2'b01) begin
      failures++; $display("FAIL c1_idle_gap got=%b exp=01", {s_cyc, m1_stall});
    end
    @(negedge clk); #1;
    checks++;
    if ({s_cyc, s_adr} !== {1'b1, 16'h00B1}) begin
      failures++; $display("FAIL c1_gnt1 got=%b/%h exp=1/00b1", s_cyc, s_adr);
    end
    drive(1, 0, 0, 0, 'hB1);
    @(negedge clk);
    drive(0, 1, 0, 0, 'hA0);
    drive(1, 1, 0, 0, 'hB1);
    @(negedge clk); #1;
    checks++;
    if ({s_cyc, s_adr, m0_stall} !== {1'b1, 16'h00B1, 1'b1}) begin
      failures++; $display("FAIL c2_gnt1_first got=%b/%h/%b exp=1/00b1/1", s_cyc, s_adr, m0_stall);
    end
    drive(1, 0, 0, 0, 'hB1);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({s_cyc, s_adr} !== {1'b1, 16'h00A0}) begin
      failures++; $display("FAIL c2_gnt0 got=%b/%h exp=1/00a0", s_cyc, s_adr);
    end
    release_bus(0);
  endtask

  task automatic test_outst_cap();
    int acks, other, af;
    ack_delay = 8;
    burst(0, 6, 1'b1, 40, 1'b1, acks, other, af);
    checks++;
    if (af !== 4) begin failures++; $display("FAIL cap_accepted_before_ack got=%0d exp=4", af); end
    checks++;
    if (acks !== 6) begin failures++; $display("FAIL cap_all_acked got=%0d exp=6", acks); end
    release_bus(0);
  endtask

  task automatic test_abort();
    int acks, other, af, s0, a0, a1;
    ack_delay = 6;
    s0 = sack_cnt;
    a0 = 0; a1 = 0;
    burst(1, 2, 1'b1, 50, 1'b0, acks, other, af);
    drive(1, 0, 0, 0, 50);
    drive(0, 1, 0, 0, 'hC3);
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin failures++; $display("FAIL abort_immediate got=%b exp=0", s_cyc); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m0_ack) a0++;
      if (m1_ack) a1++;
      #1;
      if (i == 0) begin
        checks++;
        if ({s_cyc, m0_stall} !== 2'b01) begin
          failures++; $display("FAIL abort_idle got=%b exp=01", {s_cyc, m0_stall});
        end
      end
      if (i == 1) begin
        checks++;
        if ({s_cyc, s_adr} !== {1'b1, 16'h00C3}) begin
          failures++; $display("FAIL abort_then_gnt0 got=%b/%h exp=1/00c3", s_cyc, s_adr);
        end
      end
    end
    checks++;
    if (sack_cnt - s0 !== 2) begin failures++; $display("FAIL abort_stray_acks got=%0d exp=2", sack_cnt - s0); end
    checks++;
    if ({a0, a1} !== {32'd0, 32'd0}) begin
      failures++; $display("FAIL abort_acks_dropped got=%0d/%0d exp=0/0", a0, a1);
    end
    ack_delay = 1;
    burst(0, 1, 1'b1, 60, 1'b1, acks, other, af);
    checks++;
    if ({acks, other} !== {32'd1, 32'd0}) begin
      failures++; $display("FAIL abort_next_txn got=%0d/%0d exp=1/0", acks, other);
    end
    release_bus(0);
  endtask

  task automatic test_reset_mid_burst();
    int acks, other, af;
    ack_delay = 2;
    burst(0, 3, 1'b1, 70, 1'b0, acks, other, af);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_cyc, s_stb, m0_stall, m0_ack} !== 4'b0010) begin
      failures++; $display("FAIL midreset_outputs got=%b exp=0010", {s_cyc, s_stb, m0_stall, m0_ack});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin failures++; $display("FAIL midreset_no_forward got=%b exp=0", s_cyc); end
    ack_delay = 20;
    burst(0, 6, 1'b1, 80, 1'b1, acks, other, af);
    checks++;
    if (af !== 4) begin failures++; $display("FAIL midreset_outst_cleared got=%0d exp=4", af); end
    checks++;
    if (acks !== 6) begin failures++; $display("FAIL midreset_acks got=%0d exp=6", acks); end
    release_bus(0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_outst_cap();
    test_abort();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
